// File: rtl/draw_pkg.sv
// Shared constants for the display compositor: screen geometry, background palette, transparency key.
// Colours are packed {b,g,r}, 4 bits per channel.
package draw_pkg;

  localparam logic [11:0] X_MAX  = 12'd1439;
  localparam logic [11:0] Y_MAX  = 12'd899;
  localparam logic [11:0] BORDER = 12'd11;

  localparam logic [11:0] BG_BORDER_RGB   = 12'h501;
  localparam logic [11:0] BG_FIELD_RGB    = 12'hA23;
  localparam logic [11:0] TRANSPARENT_RGB = 12'h000;

  function automatic logic [11:0] bg_colour(input logic [11:0] x, input logic [11:0] y);
    if (x < BORDER || x > X_MAX - BORDER || y < BORDER || y > Y_MAX - BORDER)
      return BG_BORDER_RGB;
    return BG_FIELD_RGB;
  endfunction

endpackage

// File: rtl/obj_hit_test.sv
// Combinational box test of one object against the current pixel; gives the hit flag and the
// low texel-coordinate bits (so larger objects tile the sprite). No state, no backpressure.
module obj_hit_test #(
  parameter int SPR_BITS = 4
) (
  input  logic                en,
  input  logic [10:0]         draw_x,
  input  logic [9:0]          draw_y,
  input  logic [10:0]         x,
  input  logic [9:0]          y,
  input  logic [7:0]          size,
  output logic                hit,
  output logic [SPR_BITS-1:0] u,
  output logic [SPR_BITS-1:0] v
);

  logic [11:0] px, py, ox, oy, half;

  assign px   = {1'b0, draw_x};
  assign py   = {2'b00, draw_y};
  assign ox   = {1'b0, x};
  assign oy   = {2'b00, y};
  assign half = {4'b0000, size} >> 1;

  // Offsetting the pixel rather than the centre keeps everything non-negative near the left/top edges.
  assign hit = en & (px + half >= ox) & (px < ox + half)
                  & (py + half >= oy) & (py < oy + half);

  assign u = SPR_BITS'(px + half - ox);
  assign v = SPR_BITS'(py + half - oy);

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor (hit test, sprite ROM address, colour mux); fixed 3-cycle latency.
// Never stalls: accepts one pixel per cycle, no backpressure; object set is frame-double-buffered.
module sprite_compositor
  import draw_pkg::*;
#(
  parameter  int NUM_OBJ   = 4,
  parameter  int SPR_W     = 16,
  parameter  int SPR_IDX_W = 4,
  localparam int SB        = $clog2(SPR_W),
  localparam int AW        = SPR_IDX_W + 2 * SB
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  input  logic [10:0]                    draw_x,
  input  logic [9:0]                     draw_y,
  input  logic                           frame_start,
  input  logic [11*NUM_OBJ-1:0]          obj_x,
  input  logic [10*NUM_OBJ-1:0]          obj_y,
  input  logic [8*NUM_OBJ-1:0]           obj_size,
  input  logic [NUM_OBJ-1:0]             obj_en,
  input  logic [NUM_OBJ-1:0]             obj_tex,
  input  logic [SPR_IDX_W*NUM_OBJ-1:0]   obj_spr,
  input  logic [12*NUM_OBJ-1:0]          obj_rgb,
  output logic [AW-1:0]                  rom_addr,
  input  logic [15:0]                    rom_data,
  output logic                           out_valid,
  output logic [3:0]                     r,
  output logic [3:0]                     g,
  output logic [3:0]                     b
);

  logic [10:0]          act_x    [NUM_OBJ];
  logic [9:0]           act_y    [NUM_OBJ];
  logic [7:0]           act_size [NUM_OBJ];
  logic [SPR_IDX_W-1:0] act_spr  [NUM_OBJ];
  logic [11:0]          act_rgb  [NUM_OBJ];
  logic [NUM_OBJ-1:0]   act_en;
  logic [NUM_OBJ-1:0]   act_tex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        act_x[i]    <= '0;
        act_y[i]    <= '0;
        act_size[i] <= '0;
        act_spr[i]  <= '0;
        act_rgb[i]  <= '0;
      end
      act_en  <= '0;
      act_tex <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        act_x[i]    <= obj_x[11*i +: 11];
        act_y[i]    <= obj_y[10*i +: 10];
        act_size[i] <= obj_size[8*i +: 8];
        act_spr[i]  <= obj_spr[SPR_IDX_W*i +: SPR_IDX_W];
        act_rgb[i]  <= obj_rgb[12*i +: 12];
      end
      act_en  <= obj_en;
      act_tex <= obj_tex;
    end
  end

  logic [NUM_OBJ-1:0] hit;
  logic [SB-1:0]      hit_u [NUM_OBJ];
  logic [SB-1:0]      hit_v [NUM_OBJ];

  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
    obj_hit_test #(.SPR_BITS(SB)) u_hit (
      .en     (act_en[gi]),
      .draw_x (draw_x),
      .draw_y (draw_y),
      .x      (act_x[gi]),
      .y      (act_y[gi]),
      .size   (act_size[gi]),
      .hit    (hit[gi]),
      .u      (hit_u[gi]),
      .v      (hit_v[gi])
    );
  end

  logic                 sel_hit, sel_tex;
  logic [11:0]          sel_rgb;
  logic [SPR_IDX_W-1:0] sel_spr;
  logic [SB-1:0]        sel_u, sel_v;

  // Walk from lowest priority upward so the lowest-index hit is the one left standing.
  always_comb begin
    sel_hit = 1'b0;
    sel_tex = 1'b0;
    sel_rgb = '0;
    sel_spr = '0;
    sel_u   = '0;
    sel_v   = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_hit = 1'b1;
        sel_tex = act_tex[i];
        sel_rgb = act_rgb[i];
        sel_spr = act_spr[i];
        sel_u   = hit_u[i];
        sel_v   = hit_v[i];
      end
    end
  end

  logic                 s1_vld, s1_hit, s1_tex;
  logic [11:0]          s1_rgb, s1_bg;
  logic [SPR_IDX_W-1:0] s1_spr;
  logic [SB-1:0]        s1_u, s1_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_tex <= 1'b0;
      s1_rgb <= '0;
      s1_bg  <= '0;
      s1_spr <= '0;
      s1_u   <= '0;
      s1_v   <= '0;
    end else begin
      s1_vld <= pix_valid;
      s1_hit <= sel_hit;
      s1_tex <= sel_tex;
      s1_rgb <= sel_rgb;
      s1_bg  <= bg_colour({1'b0, draw_x}, {2'b00, draw_y});
      s1_spr <= sel_spr;
      s1_u   <= sel_u;
      s1_v   <= sel_v;
    end
  end

  logic        s2_vld, s2_hit, s2_tex;
  logic [11:0] s2_rgb, s2_bg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld   <= 1'b0;
      s2_hit   <= 1'b0;
      s2_tex   <= 1'b0;
      s2_rgb   <= '0;
      s2_bg    <= '0;
      rom_addr <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_hit <= s1_hit;
      s2_tex <= s1_tex;
      s2_rgb <= s1_rgb;
      s2_bg  <= s1_bg;
      if (s1_vld && s1_hit && s1_tex)
        rom_addr <= {s1_spr, s1_v, s1_u};
    end
  end

  logic        unused_rom;
  logic [11:0] pix;

  assign unused_rom = ^rom_data[15:12];

  // A transparent texel shows the background, never a lower-priority object underneath.
  always_comb begin
    pix = s2_bg;
    if (s2_hit) begin
      if (!s2_tex)
        pix = s2_rgb;
      else if (rom_data[11:0] != TRANSPARENT_RGB)
        pix = rom_data[11:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      {b, g, r} <= '0;
    end else begin
      out_valid <= s2_vld;
      {b, g, r} <= s2_vld ? pix : 12'h000;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and random pixel stream against a screen-level reference of the compositor rules.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst, pix_valid, frame_start;
  logic [10:0] draw_x;
  logic [9:0]  draw_y;
  logic [43:0] obj_x;
  logic [39:0] obj_y;
  logic [31:0] obj_size;
  logic [3:0]  obj_en, obj_tex;
  logic [15:0] obj_spr;
  logic [47:0] obj_rgb;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic        out_valid;
  logic [3:0]  r, g, b;

  logic [15:0] rom [4096];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  sprite_compositor dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .draw_x(draw_x), .draw_y(draw_y),
    .frame_start(frame_start), .obj_x(obj_x), .obj_y(obj_y), .obj_size(obj_size),
    .obj_en(obj_en), .obj_tex(obj_tex), .obj_spr(obj_spr), .obj_rgb(obj_rgb),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .r(r), .g(g), .b(b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          m_x [4], m_y [4], m_size [4], m_spr [4];
  logic        m_en [4], m_tex [4];
  logic [11:0] m_rgb [4];
  logic [12:0] pipe [3];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int size, input logic en,
                         input logic tex, input int spr, input logic [11:0] rgb);
    obj_x[11*i +: 11]   = 11'(x);
    obj_y[10*i +: 10]   = 10'(y);
    obj_size[8*i +: 8]  = 8'(size);
    obj_en[i]           = en;
    obj_tex[i]          = tex;
    obj_spr[4*i +: 4]   = 4'(spr);
    obj_rgb[12*i +: 12] = rgb;
  endtask

  task automatic load_model();
    for (int i = 0; i < 4; i++) begin
      m_x[i]    = int'(obj_x[11*i +: 11]);
      m_y[i]    = int'(obj_y[10*i +: 10]);
      m_size[i] = int'(obj_size[8*i +: 8]);
      m_spr[i]  = int'(obj_spr[4*i +: 4]);
      m_en[i]   = obj_en[i];
      m_tex[i]  = obj_tex[i];
      m_rgb[i]  = obj_rgb[12*i +: 12];
    end
  endtask

  function automatic logic [11:0] model_pix(input int x, input int y);
    logic [11:0] bg, texel;
    int half, u, v;
    bg = (x < 11 || x > 1428 || y < 11 || y > 888) ? 12'h501 : 12'hA23;
    for (int i = 0; i < 4; i++) begin
      half = m_size[i] / 2;
      if (m_en[i] && x + half >= m_x[i] && x < m_x[i] + half &&
          y + half >= m_y[i] && y < m_y[i] + half) begin
        if (!m_tex[i]) return m_rgb[i];
        u = (x + half - m_x[i]) % 16;
        v = (y + half - m_y[i]) % 16;
        texel = rom[m_spr[i] * 256 + v * 16 + u][11:0];
        return (texel == 12'h000) ? bg : texel;
      end
    end
    return bg;
  endfunction

  task automatic step(input logic v, input int x, input int y, input logic fs);
    logic [12:0] e;
    pix_valid   = v;
    draw_x      = 11'(x);
    draw_y      = 10'(y);
    frame_start = fs;
    e = v ? {1'b1, model_pix(x, y)} : 13'h0000;
    if (fs) load_model();
    @(posedge clk);
    #1;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    check("out_valid", {15'b0, out_valid}, {15'b0, pipe[2][12]});
    check("rgb", {4'b0, b, g, r}, {4'b0, pipe[2][11:0]});
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    logic [31:0] tmp;
    rst = 1'b0; pix_valid = 1'b0; frame_start = 1'b0; draw_x = '0; draw_y = '0;
    obj_x = '0; obj_y = '0; obj_size = '0; obj_en = '0; obj_tex = '0; obj_spr = '0; obj_rgb = '0;
    for (int i = 0; i < 4096; i++) begin
      tmp = $urandom;
      rom[i] = ($urandom_range(0, 3) == 0) ? {tmp[15:12], 12'h000} : tmp[15:0];
    end
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    load_model();

    #2 rst = 1'b1;
    #10;
    check("reset out_valid", {15'b0, out_valid}, 16'h0000);
    check("reset rgb", {4'b0, b, g, r}, 16'h0000);
    check("reset rom_addr", {4'b0, rom_addr}, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // border pixel
    step(1'b1, 5, 5, 1'b0);
    flush();

    // solid object edges
    set_obj(0, 100, 100, 16, 1'b1, 1'b0, 0, 12'hF00);
    step(1'b0, 0, 0, 1'b1);
    step(1'b1, 92, 100, 1'b0);
    step(1'b1, 91, 100, 1'b0);
    step(1'b1, 107, 100, 1'b0);
    step(1'b1, 108, 100, 1'b0);
    step(1'b1, 100, 92, 1'b0);
    step(1'b1, 100, 91, 1'b0);
    step(1'b1, 100, 107, 1'b0);
    step(1'b1, 100, 108, 1'b0);
    flush();

    // priority between overlapping objects
    set_obj(0, 200, 200, 16, 1'b1, 1'b0, 0, 12'hF00);
    set_obj(1, 200, 200, 16, 1'b1, 1'b0, 0, 12'h0FF);
    step(1'b0, 0, 0, 1'b1);
    step(1'b1, 200, 200, 1'b0);
    step(1'b1, 195, 203, 1'b0);
    obj_en[0] = 1'b0;
    step(1'b0, 0, 0, 1'b1);
    step(1'b1, 200, 200, 1'b0);
    flush();

    // textured object, address and transparency
    rom[12'h100] = 16'hF123;
    rom[12'h101] = 16'h7000;
    set_obj(2, 300, 300, 16, 1'b1, 1'b1, 1, 12'h000);
    step(1'b0, 0, 0, 1'b1);
    step(1'b1, 292, 292, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    check("rom_addr", {4'b0, rom_addr}, 16'h0100);
    step(1'b1, 293, 292, 1'b0);
    step(1'b1, 301, 305, 1'b0);
    flush();

    // shadow change only lands at frame_start
    set_obj(1, 250, 200, 16, 1'b1, 1'b0, 0, 12'h0FF);
    step(1'b1, 200, 200, 1'b0);
    step(1'b1, 200, 200, 1'b1);
    step(1'b1, 200, 200, 1'b0);
    step(1'b1, 250, 200, 1'b0);
    flush();

    // reset with pixels in flight
    step(1'b1, 5, 5, 1'b0);
    step(1'b1, 250, 200, 1'b0);
    step(1'b1, 300, 300, 1'b0);
    pix_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("rst out_valid", {15'b0, out_valid}, 16'h0000);
    check("rst rgb", {4'b0, b, g, r}, 16'h0000);
    for (int i = 0; i < 4; i++) m_en[i] = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 250, 200, 1'b0);
    step(1'b1, 300, 300, 1'b0);
    flush();

    // random frames
    for (int f = 0; f < 15; f++) begin
      for (int i = 0; i < 4; i++)
        set_obj(i, $urandom_range(0, 160), $urandom_range(0, 160), 2 * $urandom_range(1, 32),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                12'($urandom_range(0, 4095)));
      step(1'($urandom_range(0, 1)), $urandom_range(0, 160), $urandom_range(0, 160), 1'b1);
      for (int p = 0; p < 40; p++) begin
        int x, y;
        x = ($urandom_range(0, 9) == 0) ? $urandom_range(1420, 1439) : $urandom_range(0, 160);
        y = ($urandom_range(0, 9) == 0) ? $urandom_range(880, 899) : $urandom_range(0, 160);
        if (p == 20) set_obj(0, $urandom_range(0, 160), $urandom_range(0, 160), 32, 1'b1, 1'b0, 0, 12'hF0F);
        step(1'($urandom_range(0, 3) != 0), x, y, 1'($urandom_range(0, 19) == 0));
      end
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
